mul_div_unit: RTL
=================

# mul_div_unit

Iterative RV32M multiply/divide unit that executes the operation the ALU control unit decodes for M-extension instructions (opcode 0110011, funct7[0]=1). It sits in the execute stage beside the ALU. It consumes funct3 and both operands, stalls the pipeline through a busy handshake, and returns a 32-bit result. The unit uses shift-add multiplication and restoring division, one bit per cycle.

## Interface

Parameters:
- `XLEN`, 32: operand and result width. Only 32 is supported.

Ports (name, direction, width, meaning):
- `MDU_CLOCK_50`, in, 1: single clock.
- `MDU_RESET_InHigh`, in, 1: synchronous, active-high reset.
- `MDU_Start_In`, in, 1: the execute stage holds an M-extension instruction.
- `MDU_Funct3_InBUS`, in, 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `MDU_OperandA_InBUS`, in, 32: rs1 (multiplicand or dividend).
- `MDU_OperandB_InBUS`, in, 32: rs2 (multiplier or divisor).
- `MDU_Result_OutBUS`, out, 32: registered result, held until the next accepted start.
- `MDU_Busy_Out`, out, 1: pipeline stall request.
- `MDU_Done_Out`, out, 1: one-cycle pulse; the result is valid this cycle.

## Operation

States: IDLE, MUL, DIV, DONE.

IDLE:
- `MDU_Start_In`=1 is accepted.
- On accept, latch funct3 and the sign flags:
  - sA = A[31] for MULH, MULHSU, DIV, REM; otherwise 0.
  - sB = B[31] for MULH, DIV, REM; otherwise 0.
- Latch operand magnitudes |A| and |B| using those sign flags.
- Load the 6-bit counter with 31.
- funct3[2]=0 → go to MUL.
- funct3[2]=1 with B==0 → go to DONE with the divide-by-zero result.
- funct3[2]=1 with DIV/REM, A==0x80000000 and B==0xFFFFFFFF → go to DONE with the overflow result.
- Any other funct3[2]=1 → go to DIV.

MUL:
- Each cycle: if multiplier LSB is 1, add the multiplicand to the upper half of the 64-bit accumulator; then shift the accumulator right by 1.
- After the counter=0 cycle, go to DONE.

DIV:
- Each cycle: shift {remainder, quotient} left by 1 and trial-subtract |B|.
- If the difference is ≥0, keep it and set quotient bit 0.
- After the counter=0 cycle, go to DONE.

On entry to DONE, the result register loads:
- MUL: low 32 bits of the signed-corrected product (negate the 64-bit product if sA^sB).
- MULH, MULHSU, MULHU: high 32 bits of that product.
- DIV, DIVU: quotient, negated if sA^sB.
- REM, REMU: remainder, negated if sA.
- Divide by zero: quotient 0xFFFFFFFF; remainder = A unmodified.
- Overflow: quotient 0x80000000; remainder 0.

DONE:
- `MDU_Done_Out`=1 and `MDU_Busy_Out`=0; the pipeline advances.
- Next state is always IDLE.
- `MDU_Start_In` seen in DONE is ignored; the next instruction is accepted from IDLE the following cycle.

Output logic:
- `MDU_Busy_Out` = (IDLE & `MDU_Start_In`) | MUL | DIV. It is combinational, so the stall takes effect in the accept cycle.
- `MDU_Start_In`, funct3 and operand changes during MUL or DIV are ignored; working values come from the latched copies.

## Timing

- Reset: state IDLE, `MDU_Result_OutBUS`=0, `MDU_Done_Out`=0, counter=0, accumulators=0. `MDU_Busy_Out`=0 unless `MDU_Start_In` is high.
- Reset takes priority in every state. Asserting it mid-operation aborts the operation, and the unit is IDLE the next cycle.
- Normal latency: accept at cycle T, compute cycles T+1..T+32, DONE at T+33.
- Divide-by-zero and overflow latency: accept at cycle T, DONE at T+1.
- There are no early-out shortcuts; multiply by 0 still takes 33 cycles.
- Back-to-back instructions: DONE at T+33, IDLE at T+34 accepts the next start. Minimum issue interval is 34 cycles.
- Arithmetic widths:
  - 64-bit product accumulator.
  - 33-bit trial subtraction.
  - Two's-complement negation is modulo 2^32 (results) or 2^64 (product).

## Test plan

- MUL: A=7, B=0xFFFFFFFD, start at T. Required: Busy high T..T+32; at T+33 Done=1, Busy=0, Result=0xFFFFFFEB; Result held after.
- MULH, MULHSU, MULHU:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - Each has Done at T+33.
- Signed divide:
  - DIV −7/2 → 0xFFFFFFFD.
  - REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
- Corner cases, each with Done at T+1:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Reset mid-operation: start DIV at T, assert reset at T+10. Required: at T+11 Result=0, Done=0, Busy=0 with Start low. A new MUL 3×4 started at T+12 gives 12 at T+45.
- Ignored inputs:
  - Start held high through DONE: second accept occurs at T+34, not T+33.
  - Operands changed at T+5 do not affect the result.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// A start is accepted from IDLE, and the registered result appears with a one-cycle done pulse.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            MDU_CLOCK_50,
  input  logic            MDU_RESET_InHigh,
  input  logic            MDU_Start_In,
  input  logic [2:0]      MDU_Funct3_InBUS,
  input  logic [XLEN-1:0] MDU_OperandA_InBUS,
  input  logic [XLEN-1:0] MDU_OperandB_InBUS,
  output logic [XLEN-1:0] MDU_Result_OutBUS,
  output logic            MDU_Busy_Out,
  output logic            MDU_Done_Out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q;
  logic [2:0]        funct3_q;
  logic              sa_q, sb_q;
  logic [5:0]        cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic [XLEN-1:0]   result_q;
  logic              done_q;

  logic              sa_d, sb_d, div0_d, ovf_d;
  logic [XLEN-1:0]   absa_d, absb_d;
  logic [XLEN:0]     mul_sum_d;
  logic [2*XLEN-1:0] mul_acc_d, div_acc_d;
  logic              div_ge_d;
  logic [XLEN-1:0]   div_diff_d;

  function automatic logic [XLEN-1:0] mul_result(input logic [2*XLEN-1:0] prod,
                                                 input logic [2:0] f3, input logic neg);
    logic [2*XLEN-1:0] p;
    p = neg ? (~prod + 64'd1) : prod;
    return (f3[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] div_result(input logic [2*XLEN-1:0] acc,
                                                 input logic [2:0] f3, input logic sa, input logic sb);
    logic [XLEN-1:0] q, r;
    q = (sa ^ sb) ? (~acc[XLEN-1:0] + 32'd1) : acc[XLEN-1:0];
    r = sa ? (~acc[2*XLEN-1:XLEN] + 32'd1) : acc[2*XLEN-1:XLEN];
    return f3[1] ? r : q;
  endfunction

  // Accept-time decode: sign flags, operand magnitudes and the two short-circuit divide cases.
  always_comb begin
    sa_d = 1'b0;
    sb_d = 1'b0;
    case (MDU_Funct3_InBUS)
      3'b001, 3'b100, 3'b110: begin
        sa_d = MDU_OperandA_InBUS[XLEN-1];
        sb_d = MDU_OperandB_InBUS[XLEN-1];
      end
      3'b010: begin
        sa_d = MDU_OperandA_InBUS[XLEN-1];
        sb_d = 1'b0;
      end
      default: begin
        sa_d = 1'b0;
        sb_d = 1'b0;
      end
    endcase
    absa_d = sa_d ? (~MDU_OperandA_InBUS + 32'd1) : MDU_OperandA_InBUS;
    absb_d = sb_d ? (~MDU_OperandB_InBUS + 32'd1) : MDU_OperandB_InBUS;
    div0_d = (MDU_OperandB_InBUS == 32'd0);
    ovf_d  = !MDU_Funct3_InBUS[0] && (MDU_OperandA_InBUS == 32'h8000_0000)
             && (MDU_OperandB_InBUS == 32'hFFFF_FFFF);
  end

  // One iteration of each datapath; the upper half of acc_q is the running remainder when dividing.
  always_comb begin
    mul_sum_d  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_acc_d  = {mul_sum_d, acc_q[XLEN-1:1]};
    div_ge_d   = (acc_q[2*XLEN-1:XLEN-1] >= {1'b0, opnd_q});
    div_diff_d = acc_q[2*XLEN-2:XLEN-1] - opnd_q;
    if (div_ge_d) begin
      div_acc_d = {div_diff_d, acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_acc_d = {acc_q[2*XLEN-2:0], 1'b0};
    end
  end

  // Control FSM with registered result and done pulse.
  always_ff @(posedge MDU_CLOCK_50) begin
    if (MDU_RESET_InHigh) begin
      state_q  <= S_IDLE;
      funct3_q <= 3'd0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      opnd_q   <= 32'd0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (MDU_Start_In) begin
            funct3_q <= MDU_Funct3_InBUS;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            cnt_q    <= 6'd31;
            if (!MDU_Funct3_InBUS[2]) begin
              acc_q   <= {32'd0, absb_d};
              opnd_q  <= absa_d;
              state_q <= S_MUL;
            end else if (div0_d) begin
              result_q <= MDU_Funct3_InBUS[1] ? MDU_OperandA_InBUS : 32'hFFFF_FFFF;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else if (ovf_d) begin
              result_q <= MDU_Funct3_InBUS[1] ? 32'd0 : 32'h8000_0000;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              acc_q   <= {32'd0, absa_d};
              opnd_q  <= absb_d;
              state_q <= S_DIV;
            end
          end
        end
        S_MUL: begin
          acc_q <= mul_acc_d;
          if (cnt_q == 6'd0) begin
            result_q <= mul_result(mul_acc_d, funct3_q, sa_q ^ sb_q);
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end
        S_DIV: begin
          acc_q <= div_acc_d;
          if (cnt_q == 6'd0) begin
            result_q <= div_result(div_acc_d, funct3_q, sa_q, sb_q);
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign MDU_Busy_Out      = ((state_q == S_IDLE) && MDU_Start_In) || (state_q == S_MUL) || (state_q == S_DIV);
  assign MDU_Done_Out      = done_q;
  assign MDU_Result_OutBUS = result_q;

endmodule
